// File: rtl/display_scan.sv
// display_scan: converts a 14-bit binary value (clamped to 0..9999) into four
// BCD digits using a sequential double-dabble engine. It then blanks leading
// zeros and time-multiplexes the digits onto one 4-bit code bus for a
// 4-digit common-anode display.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   value    binary value to display, sampled when a load is accepted
//   load     conversion request, honoured only while busy=0
//   busy     high while a conversion is in flight
//   done     one-cycle pulse when new digits become visible
//   bin      BCD code of the scanned digit (0..9, 15 = blank)
//   ssd_ctl  active-low digit enables, bit0 = ones, bit3 = thousands
module display_scan #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [3:0]  bin,
    output logic [3:0]  ssd_ctl
);

    localparam int            PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [13:0]   MAX_VALUE  = 14'd9999;
    // Display reads "0": three blank digits over a zero in the ones place.
    localparam logic [15:0]   DISP_RESET = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Leading-zero blanking from the thousands digit down; ones is never blanked.
    function automatic logic [15:0] blank_digits(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (BLANK_EN && (d[15:12] == 4'd0)) begin
            r[15:12] = 4'd15;
            if (d[11:8] == 4'd0) begin
                r[11:8] = 4'd15;
                if (d[7:4] == 4'd0) begin
                    r[7:4] = 4'd15;
                end else begin
                    r[7:4] = d[7:4];
                end
            end else begin
                r[11:8] = d[11:8];
            end
        end else begin
            r = d;
        end
        return r;
    endfunction

    state_t        state_r;
    logic [13:0]   sr_r;
    logic [15:0]   bcd_r;
    logic [3:0]    cnt_r;
    logic          busy_r;
    logic          done_r;
    logic [15:0]   disp_r;
    logic [PW-1:0] presc_r;
    logic [1:0]    idx_r;
    logic [3:0]    bin_r;
    logic [3:0]    ssd_ctl_r;

    logic [13:0]   value_clamped_s;
    logic [15:0]   adj_s;
    logic [15:0]   disp_next_s;
    logic [1:0]    idx_next_s;
    logic [3:0]    bin_next_s;

    // Clamp, dabble correction and next display contents.
    always_comb begin
        value_clamped_s = value;
        adj_s           = dabble_adjust(bcd_r);
        disp_next_s     = disp_r;
        if (value > MAX_VALUE) begin
            value_clamped_s = MAX_VALUE;
        end else begin
            value_clamped_s = value;
        end
        if (state_r == COMMIT) begin
            disp_next_s = blank_digits(bcd_r);
        end else begin
            disp_next_s = disp_r;
        end
    end

    // Next scan index and the digit code that will be visible with it.
    always_comb begin
        idx_next_s = idx_r;
        bin_next_s = disp_next_s[3:0];
        if (presc_r == PRESC_MAX) begin
            idx_next_s = idx_r + 2'd1;
        end else begin
            idx_next_s = idx_r;
        end
        case (idx_next_s)
            2'd0:    bin_next_s = disp_next_s[3:0];
            2'd1:    bin_next_s = disp_next_s[7:4];
            2'd2:    bin_next_s = disp_next_s[11:8];
            2'd3:    bin_next_s = disp_next_s[15:12];
            default: bin_next_s = 4'd15;
        endcase
    end

    // Conversion FSM: capture, 14 correct-and-shift steps, then commit to the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sr_r    <= 14'd0;
            bcd_r   <= 16'd0;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            disp_r  <= DISP_RESET;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load) begin
                        sr_r    <= value_clamped_s;
                        bcd_r   <= 16'd0;
                        cnt_r   <= 4'd14;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_r, sr_r} <= {adj_s, sr_r} << 5'd1;
                    cnt_r         <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_r  <= disp_next_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Free-running scan prescaler and digit index; outputs track the next display value.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r   <= {PW{1'b0}};
            idx_r     <= 2'd0;
            bin_r     <= 4'd0;
            ssd_ctl_r <= 4'b1110;
        end else begin
            if (presc_r == PRESC_MAX) begin
                presc_r <= {PW{1'b0}};
            end else begin
                presc_r <= presc_r + PW'(1);
            end
            idx_r     <= idx_next_s;
            bin_r     <= bin_next_s;
            ssd_ctl_r <= ~(4'b0001 << idx_next_s);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bin     = bin_r;
    assign ssd_ctl = ssd_ctl_r;

endmodule
